cmp_arbiter: RTL and testbench

//  Shares one Compare10 unit (ten-function W-bit compare) between R requesters.

---
 rtl/cmp_pkg.sv | 25 ++
 rtl/cmp_arbiter_rr.sv | 33 +++
 rtl/compare10.sv | 30 +++
 rtl/cmp_arbiter.sv | 141 ++++++++++++++
 tb/tb_cmp_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the compare arbiter: the function-code type,
// the ten Compare10 function codes, and the illegal-code helper.
package cmp_pkg;

  localparam int FCN_W = 4;

  typedef logic [FCN_W-1:0] cmp_fcn_t;

  localparam cmp_fcn_t FCN_EQ   = 4'd0;
  localparam cmp_fcn_t FCN_NE   = 4'd1;
  localparam cmp_fcn_t FCN_LT   = 4'd2;
  localparam cmp_fcn_t FCN_GE   = 4'd3;
  localparam cmp_fcn_t FCN_LTU  = 4'd4;
  localparam cmp_fcn_t FCN_GEU  = 4'd5;
  localparam cmp_fcn_t FCN_GT   = 4'd6;
  localparam cmp_fcn_t FCN_LE   = 4'd7;
  localparam cmp_fcn_t FCN_GTU  = 4'd8;
  localparam cmp_fcn_t FCN_LEU  = 4'd9;
  localparam cmp_fcn_t FCN_LAST = 4'd9;

  function automatic logic fcn_illegal(input cmp_fcn_t f);
    return (f > FCN_LAST);
  endfunction

endpackage

// File: rtl/cmp_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr
// with wrap; gnt is one-hot or zero, and zero whenever en is low.
module rr_arbiter #(
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [R-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  // Scan R positions starting at ptr; the first requesting one wins
  always_comb begin
    logic found;
    logic hit;
    int   sum;
    int   idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < R; k++) begin
      sum  = int'(ptr) + k;
      idx  = (sum >= R) ? (sum - R) : sum;
      hit  = en & ~found & req[IDW'(idx)];
      gnt[IDW'(idx)] = hit;
      gnt_idx = hit ? IDW'(idx) : gnt_idx;
      found   = found | hit;
    end
  end

endmodule

// File: rtl/compare10.sv
// Compare10: combinational ten-function W-bit comparator.
// Codes above 9 produce 0.
module Compare10 #(
  parameter int W = 32
) (
  input  logic [3:0]   fcn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out
);

  // Function decode; signed variants reinterpret the operands as two's complement
  always_comb begin
    out = 1'b0;
    case (fcn)
      4'd0:    out = (a == b);
      4'd1:    out = (a != b);
      4'd2:    out = ($signed(a) <  $signed(b));
      4'd3:    out = ($signed(a) >= $signed(b));
      4'd4:    out = (a <  b);
      4'd5:    out = (a >= b);
      4'd6:    out = ($signed(a) >  $signed(b));
      4'd7:    out = ($signed(a) <= $signed(b));
      4'd8:    out = (a >  b);
      4'd9:    out = (a <= b);
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: R requesters share one Compare10 through a 2-stage pipeline
// (S1 operands, S2 response). Optional macro CMP_ARB_FCN_CHECK_EN flags codes 10..15.
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int  W   = 32,
  parameter int  R   = 4,
  localparam int IDW = (R > 1) ? $clog2(R) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     req_valid,
  output logic [R-1:0]     req_ready,
  input  logic [R*4-1:0]   req_fcn,
  input  logic [R*W-1:0]   req_a,
  input  logic [R*W-1:0]   req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic             rsp_out,
  output logic             rsp_err
);

  logic           stall_s, adv_s, load_s;
  logic [R-1:0]   gnt_s;
  logic [IDW-1:0] gnt_idx_s, ptr_inc_s;
  logic           cmp_res_s, res_s;
  cmp_fcn_t       sel_f_s;
  logic [W-1:0]   sel_a_s, sel_b_s;

  logic           s1_valid_q, s1_valid_d;
  cmp_fcn_t       f_q, f_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [IDW-1:0] id_q, id_d, rr_ptr_q, rr_ptr_d;
  logic           rsp_valid_q, rsp_valid_d, rsp_out_q, rsp_out_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  assign stall_s = rsp_valid_q & ~rsp_ready;
  assign adv_s   = ~stall_s;

  // Reset also silences the grant so nothing is accepted during rst
  rr_arbiter #(.R(R), .IDW(IDW)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (adv_s & ~rst),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign req_ready = gnt_s;
  assign load_s    = |gnt_s;
  assign ptr_inc_s = (gnt_idx_s == IDW'(R - 1)) ? '0 : (gnt_idx_s + IDW'(1));

  // One-hot AND-OR mux of the granted requester's slice
  always_comb begin
    sel_f_s = '0;
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < R; i++) begin
      sel_f_s = sel_f_s | ({FCN_W{gnt_s[i]}} & req_fcn[FCN_W*i +: FCN_W]);
      sel_a_s = sel_a_s | ({W{gnt_s[i]}} & req_a[W*i +: W]);
      sel_b_s = sel_b_s | ({W{gnt_s[i]}} & req_b[W*i +: W]);
    end
  end

  Compare10 #(.W(W)) u_cmp (
    .fcn (f_q),
    .a   (a_q),
    .b   (b_q),
    .out (cmp_res_s)
  );

`ifdef CMP_ARB_FCN_CHECK_EN
  logic fcn_bad_s;
  logic rsp_err_q, rsp_err_d;

  assign fcn_bad_s = fcn_illegal(f_q);
  assign res_s     = cmp_res_s & ~fcn_bad_s;
  assign rsp_err_d = adv_s ? fcn_bad_s : rsp_err_q;
  assign rsp_err   = rsp_err_q;

  // Error flag travels with the rest of S2
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end
`else
  assign res_s   = cmp_res_s;
  assign rsp_err = 1'b0;
`endif

  // S1 loads on an accepted transfer and empties on an idle advance
  always_comb begin
    s1_valid_d = adv_s ? load_s : s1_valid_q;
    f_d        = load_s ? sel_f_s   : f_q;
    a_d        = load_s ? sel_a_s   : a_q;
    b_d        = load_s ? sel_b_s   : b_q;
    id_d       = load_s ? gnt_idx_s : id_q;
    rr_ptr_d   = load_s ? ptr_inc_s : rr_ptr_q;
  end

  // S2 takes S1 and the compare result whenever the pipe advances
  always_comb begin
    rsp_valid_d = adv_s ? s1_valid_q : rsp_valid_q;
    rsp_id_d    = adv_s ? id_q       : rsp_id_q;
    rsp_out_d   = adv_s ? res_s      : rsp_out_q;
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      f_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_out_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      f_q         <= f_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: per-requester op queues drive the ports, accepted
// ops push expected responses to a scoreboard that is checked on each pop.
module tb_cmp_arbiter;

  localparam int W   = 32;
  localparam int R   = 4;
  localparam int IDW = 2;
  localparam int QD  = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [R-1:0]     req_valid = '0;
  logic [R-1:0]     req_ready;
  logic [R*4-1:0]   req_fcn = '0;
  logic [R*W-1:0]   req_a = '0;
  logic [R*W-1:0]   req_b = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [IDW-1:0]   rsp_id;
  logic             rsp_out;
  logic             rsp_err;

  cmp_arbiter #(.W(W), .R(R)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fcn(req_fcn), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   fcn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         eo;
    logic         ee;
  } op_t;

  typedef struct {
    int   id;
    logic out;
    logic err;
  } exp_t;

  typedef struct {
    logic [3:0]   fcn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         eo;
  } vec_t;

  op_t  ops [R][QD];
  int   head [R];
  int   tail [R];
  exp_t sb [$];
  int   grant_log [$];
  int   acc_cyc [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pops = 0;
  int   valid_cycles = 0;
  int   pop_cyc_last = 0;
  vec_t tbl [12];

  function automatic logic model_cmp(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    case (f)
      4'd0:    return a == b;
      4'd1:    return a != b;
      4'd2:    return $signed(a) <  $signed(b);
      4'd3:    return $signed(a) >= $signed(b);
      4'd4:    return a <  b;
      4'd5:    return a >= b;
      4'd6:    return $signed(a) >  $signed(b);
      4'd7:    return $signed(a) <= $signed(b);
      4'd8:    return a >  b;
      4'd9:    return a <= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_err(input logic [3:0] f);
`ifdef CMP_ARB_FCN_CHECK_EN
    return f > 4'd9;
`else
    return (f != f);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic enq_x(input int id, input logic [3:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic eo, input logic ee);
    op_t o;
    o.fcn = f; o.a = a; o.b = b; o.eo = eo; o.ee = ee;
    ops[id][tail[id]] = o;
    tail[id]++;
  endtask

  task automatic enq(input int id, input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    enq_x(id, f, a, b, model_cmp(f, a, b), model_err(f));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pending();
    for (int i = 0; i < R; i++) head[i] = tail[i];
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !rsp_valid;
      for (int i = 0; i < R; i++) if (head[i] != tail[i]) done = 1'b0;
    end
    check({name, "_idle"}, 32'(done), 32'd1);
  endtask

  always @(posedge clk) cyc++;

  // Requester model: present the head op of each queue, hold until accepted
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < R; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i]       = 1'b1;
        req_fcn[4*i +: 4]  = ops[i][head[i]].fcn;
        req_a[W*i +: W]    = ops[i][head[i]].a;
        req_b[W*i +: W]    = ops[i][head[i]].b;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  // Monitor: pops compared against the scoreboard, accepts push expectations
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (rsp_valid) valid_cycles++;
      if (rsp_valid && rsp_ready) begin
        pops++;
        pop_cyc_last = cyc;
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_out", 32'(rsp_out), 32'(e.out));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
      for (int i = 0; i < R; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          check("ready_onehot", 32'($countones(req_ready)), 32'd1);
          e.id  = i;
          e.out = ops[i][head[i]].eo;
          e.err = ops[i][head[i]].ee;
          sb.push_back(e);
          grant_log.push_back(i);
          acc_cyc.push_back(cyc);
          head[i]++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, a0, ok;
    tbl[0]  = '{4'd0, 32'd5,          32'd5,          1'b1};
    tbl[1]  = '{4'd0, 32'd5,          32'd6,          1'b0};
    tbl[2]  = '{4'd1, 32'd5,          32'd6,          1'b1};
    tbl[3]  = '{4'd2, 32'hFFFF_FFFF,  32'd1,          1'b1};
    tbl[4]  = '{4'd4, 32'hFFFF_FFFF,  32'd1,          1'b0};
    tbl[5]  = '{4'd3, 32'h8000_0000,  32'h7FFF_FFFF,  1'b0};
    tbl[6]  = '{4'd5, 32'h8000_0000,  32'h7FFF_FFFF,  1'b1};
    tbl[7]  = '{4'd6, 32'h7FFF_FFFF,  32'h8000_0000,  1'b1};
    tbl[8]  = '{4'd7, 32'd3,          32'd3,          1'b1};
    tbl[9]  = '{4'd8, 32'd0,          32'hFFFF_FFFF,  1'b0};
    tbl[10] = '{4'd9, 32'd0,          32'hFFFF_FFFF,  1'b1};
    tbl[11] = '{4'd9, 32'd5,          32'd4,          1'b0};
    for (int i = 0; i < R; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end

    // Reset held with every requester asserting
    for (int i = 0; i < R; i++) enq(i, 4'd0, 32'd1, 32'd1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_out", 32'(rsp_out), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
    end
    @(posedge clk);
    clear_pending();
    #1;
    rst = 1'b0;
    tick();

    // Round-robin with all four asserting continuously
    grant_log.delete();
    acc_cyc.delete();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < R; i++) enq(i, 4'(2 + i), 32'(i * 7 + k), 32'(13 - i));
    wait_idle("rr");
    check("rr_count", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
      check("rr_order", 32'(grant_log[k]), 32'(k % 4));
      if (k > 0) check("rr_one_per_cycle", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd1);
    end

    // Single op latency from R0
    valid_cycles = 0;
    p0 = pops;
    acc_cyc.delete();
    enq_x(0, 4'd0, 32'd5, 32'd5, 1'b1, 1'b0);
    wait_idle("single");
    check("single_pops", 32'(pops - p0), 32'd1);
    check("single_valid_cycles", 32'(valid_cycles), 32'd1);
    if (acc_cyc.size() == 1) check("single_latency", 32'(pop_cyc_last - acc_cyc[0]), 32'd2);
    else check("single_accepts", 32'(acc_cyc.size()), 32'd1);

    // Vector table spread over the requesters
    p0 = pops;
    for (int k = 0; k < 12; k++) enq_x(k % 4, tbl[k].fcn, tbl[k].a, tbl[k].b, tbl[k].eo, 1'b0);
    wait_idle("table");
    check("table_pops", 32'(pops - p0), 32'd12);

    // Backpressure: pipe fills, then freezes for five cycles
    p0 = pops;
    rsp_ready = 1'b0;
    enq(0, 4'd1, 32'd9, 32'd9);
    enq(1, 4'd4, 32'd2, 32'd3);
    enq(2, 4'd6, 32'hFFFF_FFF0, 32'd1);
    ok = 0;
    for (int n = 0; n < 20 && ok == 0; n++) begin
      @(negedge clk);
      if (rsp_valid && sb.size() == 2) ok = 1;
    end
    check("bp_fill", 32'(ok), 32'd1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_inflight", 32'(sb.size()), 32'd2);
      if (sb.size() > 0) begin
        check("bp_id_frozen", 32'(rsp_id), 32'(sb[0].id));
        check("bp_out_frozen", 32'(rsp_out), 32'(sb[0].out));
      end
    end
    tick();
    rsp_ready = 1'b1;
    wait_idle("bp");
    check("bp_pops", 32'(pops - p0), 32'd3);

    // Illegal function code from R2
    p0 = pops;
    enq(2, 4'd12, 32'd1, 32'd1);
    wait_idle("cfg");
    check("cfg_pops", 32'(pops - p0), 32'd1);

    // Reset with S1 and S2 both occupied
    rsp_ready = 1'b0;
    enq(1, 4'd0, 32'd4, 32'd4);
    enq(2, 4'd1, 32'd4, 32'd4);
    enq(3, 4'd8, 32'd9, 32'd4);
    ok = 0;
    for (int n = 0; n < 20 && ok == 0; n++) begin
      @(negedge clk);
      if (rsp_valid && sb.size() == 2) ok = 1;
    end
    check("mid_fill", 32'(ok), 32'd1);
    tick();
    rst = 1'b1;
    clear_pending();
    tick();
    tick();
    @(posedge clk);
    clear_pending();
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(rsp_valid), 32'd0);
    end
    grant_log.delete();
    a0 = pops;
    for (int i = 0; i < R; i++) enq(i, 4'd5, 32'(i), 32'd2);
    wait_idle("post_rst");
    check("post_rst_pops", 32'(pops - a0), 32'd4);
    if (grant_log.size() > 0) check("post_rst_first_grant", 32'(grant_log[0]), 32'd0);
    else check("post_rst_grants", 32'(grant_log.size()), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
